ysyx_22041211_ifu: RTL
======================

# ysyx_22041211_ifu

Instruction fetch unit for the ysyx_22041211 NPC core: holds the architectural PC and issues one word fetch at a time to instruction memory over a valid/ready request channel. It buffers the returned instruction and presents `{inst_o, pc_o}` to the decoder with a valid/ready handshake. It accepts a branch redirect from the branch-resolution path and discards any in-flight fetch made stale by that redirect.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC after reset.
- `clk  in  1`: core clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `req_valid_o  out  1`: fetch request to instruction memory.
- `req_ready_i  in  1`: memory accepts the request this cycle.
- `req_addr_o  out  32`: fetch address, equal to the current PC.
- `rsp_valid_i  in  1`: read data valid; always accepted.
- `rsp_data_i  in  32`: fetched instruction word.
- `valid_o  out  1`: instruction available to the decoder.
- `ready_i  in  1`: decoder consumes the instruction.
- `inst_o  out  32`: buffered instruction.
- `pc_o  out  32`: PC of `inst_o`.
- `redirect_valid_i  in  1`: taken branch or jump, one-cycle pulse.
- `redirect_pc_i  in  32`: redirect target.
- `misalign_o  out  1`: misaligned redirect target trapped. Present only under the macro in Configuration.

## Operation
- FSM states, encoded in 2 bits:
  - `REQ`: `req_valid_o=1`.
  - `WAIT`: request accepted, response pending.
  - `HOLD`: `valid_o=1`.
  - `ERR`: halted; exists only with the macro.
- `REQ`:
  - If `req_ready_i`, go to `WAIT`.
  - Otherwise stay in `REQ`; `req_addr_o` holds the PC.
- `WAIT`:
  - On `rsp_valid_i`, latch `rsp_data_i` into `inst_o` and go to `HOLD`.
  - If `drop` is set, discard the data, clear `drop`, and go to `REQ`.
- `HOLD`:
  - On `valid_o && ready_i`, set PC to PC+4 (mod 2^32, wraps) and go to `REQ`.
  - Otherwise hold `inst_o` and `pc_o` stable.
- Redirect has top priority in every state. It sets PC to `redirect_pc_i` at the same edge, and PC+4 is never applied that cycle.
  - In `REQ` with `req_ready_i=0`: stay in `REQ`; the new address appears on the next cycle.
  - In `REQ` with `req_ready_i=1`: go to `WAIT` with `drop=1`.
  - In `WAIT`: set `drop=1`. If `rsp_valid_i` arrives in the same cycle, discard the data and go to `REQ`.
  - In `HOLD`: go to `REQ`; `valid_o` falls at the next edge. If a decoder fire occurs in the same cycle, the instruction is consumed and the redirect PC wins.
- Only one outstanding request is allowed. `rsp_valid_i` outside `WAIT` is ignored.

## Timing
- Reset values:
  - PC is `RESET_PC`.
  - State is `REQ`, so `req_valid_o=1` in the first cycle after `rst_n` rises.
  - `valid_o=0`, `inst_o=0`, `drop=0`, `misalign_o=0`.
- Reset asserted mid-operation returns to these values immediately; any outstanding response is not tracked.
- With a zero-wait memory (`req_ready_i=1`, `rsp_valid_i` one cycle later):
  - Request accepted in cycle t.
  - Response arrives in t+1.
  - `valid_o` rises in t+2.
  - With `ready_i=1`, the next request goes out in t+3, so throughput is one instruction per 3 cycles.
- `pc_o` always equals the address the `inst_o` word was fetched from.
- `req_addr_o` and `pc_o` are both driven from the PC register.

## Configuration
- Macro `YSYX_22041211_IFU_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc_i[1:0]!=0` sets `misalign_o=1`, loads the PC with that target, and moves to `ERR`.
  - `ERR` deasserts `req_valid_o` and `valid_o` and is left only by reset.
- Undefined:
  - `redirect_pc_i[1:0]` is forced to `2'b00` when loaded.
  - There is no `misalign_o` port and no `ERR` state.

## Structure
- `ysyx_22041211_define.v` holds:
  - `IFU_RESET_PC`.
  - FSM state encodings `IFU_REQ`, `IFU_WAIT`, `IFU_HOLD`, `IFU_ERR`.
  - The 32-bit `INST_WIDTH`.
- One sub-module, `ysyx_22041211_pc_reg`: PC register with async active-low reset to `RESET_PC`, plus load-redirect and increment-by-4 controls.

## Test plan
- Reset release with zero-wait memory returning `0x00000093` (addi):
  - `req_addr_o=0x80000000` in cycle 1.
  - `valid_o=1`, `inst_o=0x00000093`, `pc_o=0x80000000` in cycle 3.
- Decoder stall: `ready_i=0` for 5 cycles in `HOLD`.
  - `inst_o` and `pc_o` stay stable; no new request.
  - On `ready_i=1`, the next `req_addr_o` is `0x80000004`.
- Redirect to `0x80000100` while in `WAIT`:
  - The response word is dropped and `valid_o` stays 0.
  - The next request goes to `0x80000100`.
- Redirect in `HOLD` in the same cycle as a decoder fire: the next `req_addr_o` is the target, not PC+4.
- Memory backpressure, `req_ready_i=0` for 3 cycles: `req_valid_o` stays 1 with a constant address until accepted.
- Misaligned redirect to `0x80000102`:
  - With the macro: `misalign_o=1` and fetch halts.
  - Without it: the fetch goes to `0x80000100`.

Source files
------------

// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared definitions for the ysyx_22041211 instruction fetch unit:
// reset PC, instruction width, FSM state encodings and address helpers.
package ysyx_22041211_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int unsigned INST_WIDTH   = 32;

  // Fetch FSM encodings. IFU_ERR is only reachable when the misalignment
  // trap is built in (YSYX_22041211_IFU_MISALIGN_CHECK_EN).
  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2,
    IFU_ERR  = 2'd3
  } ifu_state_e;

  // Clear the byte offset so the address points at a whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // True when the address is not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_22041211_pc_reg.sv
// Architectural PC register: async active-low reset to RESET_PC, a load
// port for redirects (takes priority) and an increment-by-4 port.
module ysyx_22041211_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next PC: a redirect load beats the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit for the ysyx_22041211 NPC core.
// One outstanding word fetch at a time; the returned word is buffered and
// offered to the decoder with a valid/ready handshake. A redirect always
// wins and marks any in-flight fetch as stale so its data is discarded.
// Optional feature macro: YSYX_22041211_IFU_MISALIGN_CHECK_EN traps
// misaligned redirect targets into a halted ERR state (adds misalign_o).
module ysyx_22041211_ifu
  import ysyx_22041211_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [31:0]             req_addr_o,
  input  logic                    rsp_valid_i,
  input  logic [INST_WIDTH-1:0]   rsp_data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [INST_WIDTH-1:0]   inst_o,
  output logic [31:0]             pc_o,
  input  logic                    redirect_valid_i,
  input  logic [31:0]             redirect_pc_i
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
  ,
  output logic                    misalign_o
`endif
);

  ifu_state_e            state_d;
  ifu_state_e            state_q;
  logic                  drop_d;
  logic                  drop_q;
  logic [INST_WIDTH-1:0] inst_d;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  pc_load_s;
  logic                  pc_inc_s;
  logic [31:0]           pc_target_s;
  logic [31:0]           pc_s;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
  logic                  misalign_d;
  logic                  misalign_q;
`endif

  ysyx_22041211_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pc_load_s),
    .load_pc_i (pc_target_s),
    .inc_i     (pc_inc_s),
    .pc_o      (pc_s)
  );

  // Next-state, stale-fetch tracking and PC control; redirect has top priority.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    inst_d      = inst_q;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    pc_target_s = word_align(redirect_pc_i);
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      IFU_REQ: begin
        if (redirect_valid_i) begin
          pc_load_s = 1'b1;
          if (req_ready_i) begin
            // The accepted request carries the old PC, so its data is stale.
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = IFU_REQ;
          end
        end else if (req_ready_i) begin
          state_d = IFU_WAIT;
        end else begin
          state_d = IFU_REQ;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid_i) begin
          pc_load_s = 1'b1;
          if (rsp_valid_i) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end
        end else if (rsp_valid_i) begin
          if (drop_q) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = IFU_HOLD;
            inst_d  = rsp_data_i;
          end
        end else begin
          state_d = IFU_WAIT;
        end
      end
      IFU_HOLD: begin
        if (redirect_valid_i) begin
          // A simultaneous decoder fire still consumes the word, but the
          // redirect target replaces PC+4.
          pc_load_s = 1'b1;
          state_d   = IFU_REQ;
        end else if (ready_i) begin
          pc_inc_s = 1'b1;
          state_d  = IFU_REQ;
        end else begin
          state_d = IFU_HOLD;
        end
      end
      IFU_ERR: begin
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
        state_d = IFU_ERR;
`else
        state_d = IFU_REQ;
`endif
      end
      default: begin
        state_d = IFU_REQ;
      end
    endcase
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
    // A misaligned target is loaded verbatim and halts fetch until reset.
    if (redirect_valid_i && (state_q != IFU_ERR) && is_misaligned(redirect_pc_i)) begin
      pc_load_s   = 1'b1;
      pc_target_s = redirect_pc_i;
      state_d     = IFU_ERR;
      drop_d      = 1'b0;
      inst_d      = inst_q;
      misalign_d  = 1'b1;
    end else begin
      misalign_d  = misalign_q;
    end
`endif
  end

  // FSM, stale-fetch flag and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_REQ;
      drop_q  <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
  // Sticky misalignment trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign req_valid_o = (state_q == IFU_REQ);
  assign valid_o     = (state_q == IFU_HOLD);
  assign req_addr_o  = pc_s;
  assign pc_o        = pc_s;
  assign inst_o      = inst_q;

endmodule
